// File: rtl/cpu_spi_flash.sv
// cpu_spi_flash: CPU bus device driving the configuration/boot flash as a
// byte-wide SPI master (mode 0). Firmware controls chip select through CSR,
// starts an 8-bit full-duplex transfer by writing DATA, polls BUSY, then
// reads the received byte back from DATA.
module cpu_spi_flash #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_req,
    input  logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_wdata,
    output logic        bus_ack,
    output logic [31:0] bus_rdata,
    output logic        flash_cs,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] rx_byte;

    logic is_read;
    logic is_write;
    logic sel_data;
    logic busy;
    logic cnt_last;
    logic unused_bits;

    assign is_read  = bus_req && (bus_wstrb == 4'b0000);
    assign is_write = bus_req && bus_wstrb[0];
    assign sel_data = bus_address[2];
    assign busy     = (state != ST_IDLE);
    assign cnt_last = (cnt == CNT_LAST);

    // Address bits other than [2], upper strobes and upper write data are not decoded.
    assign unused_bits = ^{bus_address[31:3], bus_address[1:0], bus_wstrb[3:1], bus_wdata[31:8]};

    // Bus side: one-cycle ack for every request, read mux, chip-select register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            flash_cs  <= 1'b1;
        end else begin
            bus_ack   <= bus_req;
            bus_rdata <= '0;
            if (is_read) begin
                if (sel_data) begin
                    bus_rdata <= {24'h0, rx_byte};
                end else begin
                    bus_rdata <= {30'h0, busy, ~flash_cs};
                end
            end
            if (is_write && !sel_data) begin
                flash_cs <= ~bus_wdata[0];
            end
        end
    end

    // SPI engine: each bit is one LOW and one HIGH half-period of CLK_DIV cycles;
    // MISO is sampled on the rising SCK edge, MOSI advances on the falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            flash_sck  <= 1'b0;
            flash_mosi <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_write && sel_data) begin
                        shreg      <= bus_wdata[7:0];
                        flash_mosi <= bus_wdata[7];
                        cnt        <= '0;
                        bit_cnt    <= '0;
                        state      <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (cnt_last) begin
                        cnt       <= '0;
                        flash_sck <= 1'b1;
                        shreg     <= {shreg[6:0], flash_miso};
                        state     <= ST_HIGH;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_last) begin
                        cnt       <= '0;
                        flash_sck <= 1'b0;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_byte <= shreg;
                            state   <= ST_IDLE;
                        end else begin
                            // After the shift, bit 7 holds the next data bit to send.
                            flash_mosi <= shreg[7];
                            state      <= ST_LOW;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_spi_flash.sv
// Directed bench for cpu_spi_flash: bus accesses push their expected read data
// into a queue that a monitor drains on every bus_ack; SPI-side counters and
// direct checks cover transfer length, bit order, busy handling and reset.
module tb_cpu_spi_flash;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_req = 1'b0;
    logic [3:0]  bus_wstrb = '0;
    logic [31:0] bus_address = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        flash_cs;
    logic        flash_sck;
    logic        flash_mosi;
    logic        flash_miso;

    logic loopback = 1'b1;
    logic miso_tie = 1'b0;
    assign flash_miso = loopback ? flash_mosi : miso_tie;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    int         busy_cycles = 0;
    int         sck_rises = 0;
    logic       sck_prev = 1'b0;
    logic [7:0] mosi_cap = '0;
    logic       mosi_seen_high = 1'b0;

    cpu_spi_flash #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_req    (bus_req),
        .bus_wstrb  (bus_wstrb),
        .bus_address(bus_address),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .flash_cs   (flash_cs),
        .flash_sck  (flash_sck),
        .flash_mosi (flash_mosi),
        .flash_miso (flash_miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every ack pops one expectation; rdata must be 0 without ack.
    always @(negedge clk) begin
        if (bus_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                check(name_q.pop_front(), bus_rdata, exp_q.pop_front());
            end
        end else if (bus_rdata !== 32'h0) begin
            check("rdata_idle_zero", bus_rdata, 32'h0);
        end
    end

    // SPI observer: busy cycles, SCK rises, MOSI captured at each rise.
    always @(negedge clk) begin
        if (dut.busy) busy_cycles++;
        if (dut.busy && flash_mosi) mosi_seen_high = 1'b1;
        if (flash_sck && !sck_prev) begin
            sck_rises++;
            mosi_cap = {mosi_cap[6:0], flash_mosi};
        end
        sck_prev = flash_sck;
    end

    task automatic clear_obs();
        busy_cycles    = 0;
        sck_rises      = 0;
        mosi_cap       = '0;
        mosi_seen_high = 1'b0;
    endtask

    // One bus access; expected rdata is 0 for any non-read access.
    task automatic bus_access(input string name, input logic [31:0] addr, input logic [3:0] strb,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata);
        @(posedge clk);
        #1;
        bus_req     = 1'b1;
        bus_address = addr;
        bus_wstrb   = strb;
        bus_wdata   = wdata;
        exp_q.push_back((strb == 4'b0000) ? exp_rdata : 32'h0);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        bus_req   = 1'b0;
        bus_wstrb = '0;
        bus_wdata = '0;
        check({name, "_ack_timing"}, {31'h0, bus_ack}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (dut.busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (dut.busy) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_cs", {31'h0, flash_cs}, 32'd1);
        check("rst_sck", {31'h0, flash_sck}, 32'd0);
        check("rst_mosi", {31'h0, flash_mosi}, 32'd0);
        check("rst_ack", {31'h0, bus_ack}, 32'd0);

        bus_access("rst_csr", 32'h0, 4'b0000, 32'h0, 32'h0);
        bus_access("rst_data", 32'h4, 4'b0000, 32'h0, 32'h0);

        // Write with only an upper strobe must not touch CS_EN.
        bus_access("csr_wstrb2", 32'h0, 4'b0010, 32'h1, 32'h0);
        bus_access("csr_after_wstrb2", 32'h0, 4'b0000, 32'h0, 32'h0);
        check("cs_after_wstrb2", {31'h0, flash_cs}, 32'd1);

        bus_access("csr_wr_en", 32'h0, 4'b1111, 32'h1, 32'h0);
        check("cs_enabled", {31'h0, flash_cs}, 32'd0);
        bus_access("csr_rd_en", 32'h0, 4'b0000, 32'h0, 32'h1);

        // Loopback transfer of 0xA5.
        loopback = 1'b1;
        clear_obs();
        bus_access("data_wr_a5", 32'h4, 4'b0001, 32'hA5, 32'h0);
        bus_access("csr_busy", 32'h0, 4'b0000, 32'h0, 32'h3);
        wait_idle("a5");
        check("a5_sck_rises", sck_rises, 32'd8);
        check("a5_busy_cycles", busy_cycles, 32'd64);
        check("a5_mosi_order", {24'h0, mosi_cap}, 32'hA5);
        bus_access("csr_idle", 32'h0, 4'b0000, 32'h0, 32'h1);
        bus_access("data_rd_a5", 32'h4, 4'b0000, 32'h0, 32'hA5);

        // MISO tied high, send 0x00.
        loopback = 1'b0;
        miso_tie = 1'b1;
        clear_obs();
        bus_access("data_wr_00", 32'h4, 4'b0001, 32'h00, 32'h0);
        wait_idle("zero");
        check("zero_sck_rises", sck_rises, 32'd8);
        check("zero_busy_cycles", busy_cycles, 32'd64);
        check("zero_mosi_low", {31'h0, mosi_seen_high}, 32'd0);
        bus_access("data_rd_ff", 32'h4, 4'b0000, 32'h0, 32'hFF);

        // Second DATA write while busy is acked but ignored.
        loopback = 1'b1;
        miso_tie = 1'b0;
        clear_obs();
        bus_access("data_wr_81", 32'h4, 4'b0001, 32'h81, 32'h0);
        repeat (5) @(posedge clk);
        bus_access("data_wr_3c_busy", 32'h4, 4'b0001, 32'h3C, 32'h0);
        wait_idle("x81");
        check("x81_sck_rises", sck_rises, 32'd8);
        check("x81_mosi_order", {24'h0, mosi_cap}, 32'h81);
        bus_access("data_rd_81", 32'h4, 4'b0000, 32'h0, 32'h81);

        // Reset in the middle of a transfer.
        bus_access("data_wr_ff", 32'h4, 4'b0001, 32'hFF, 32'h0);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_cs", {31'h0, flash_cs}, 32'd1);
        check("midrst_sck", {31'h0, flash_sck}, 32'd0);
        check("midrst_busy", {31'h0, dut.busy}, 32'd0);
        bus_access("midrst_data", 32'h4, 4'b0000, 32'h0, 32'h0);
        bus_access("midrst_csr", 32'h0, 4'b0000, 32'h0, 32'h0);

        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
